row_uram_arbiter: RTL and testbench

ROW_URAM_ARBITER -- requirements
Module: row_uram_arbiter

---
 rtl/row_uram_arbiter.sv | 139 +++++++++++++
 tb/tb_row_uram_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/row_uram_arbiter.sv
// Round-robin arbiter that lets NUM_CORES cores share one row URAM.
// It also tracks how many words were written and whether the host has drained the URAM since.
module row_uram_arbiter #(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned WRCNT_WIDTH = 13
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CORES-1:0]      i_core_req,
  input  logic [NUM_CORES-1:0]      i_core_locked,
  output logic [NUM_CORES-1:0]      o_core_grant,
  input  logic [NUM_CORES-1:0]      i_URAM_en,
  input  logic [12*NUM_CORES-1:0]   i_URAM_addr,
  input  logic [32*NUM_CORES-1:0]   i_URAM_wr_data,
  input  logic [NUM_CORES-1:0]      i_URAM_wr_en,
  output logic                      o_URAM_en,
  output logic [11:0]               o_URAM_addr,
  output logic [31:0]               o_URAM_wr_data,
  output logic                      o_URAM_wr_en,
  input  logic                      i_host_drain_done,
  output logic                      o_uram_emptied,
  output logic [WRCNT_WIDTH-1:0]    o_wr_count
);

  localparam int unsigned GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [WRCNT_WIDTH-1:0] WR_SAT = WRCNT_WIDTH'(4096);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          g_q, g_d, p_q, p_d;
  logic [NUM_CORES-1:0]   grant_q, grant_d;
  logic [GW-1:0]          sel_idx;
  logic                   sel_found;
  logic [GW:0]            cand;
  logic                   emptied_q, emptied_d;
  logic                   pend_q, pend_d;
  logic [WRCNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   owned;
  logic                   wr;

  assign owned = (state_q == OWNED);

  // First requester at or after p, wrapping modulo NUM_CORES.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      cand = {1'b0, p_q} + (GW+1)'(i);
      if (cand >= (GW+1)'(NUM_CORES)) cand = cand - (GW+1)'(NUM_CORES);
      if (!sel_found && i_core_req[cand[GW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          g_d     = sel_idx;
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (!(i_core_req[g_q] | i_core_locked[g_q])) begin
          state_d = IDLE;
          p_d     = (g_q == GW'(NUM_CORES - 1)) ? '0 : g_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = (state_d == OWNED) ? (NUM_CORES'(1) << g_d) : '0;
  end

  always_comb begin
    o_URAM_en      = 1'b0;
    o_URAM_addr    = '0;
    o_URAM_wr_data = '0;
    o_URAM_wr_en   = 1'b0;
    if (owned) begin
      o_URAM_en      = i_URAM_en[g_q];
      o_URAM_addr    = i_URAM_addr[12*32'(g_q) +: 12];
      o_URAM_wr_data = i_URAM_wr_data[32*32'(g_q) +: 32];
      o_URAM_wr_en   = i_URAM_wr_en[g_q];
    end
  end

  assign wr = o_URAM_en & o_URAM_wr_en;

  // A write beats a coincident drain; a drain seen while owned waits for IDLE
  // and is discarded if a write lands before then.
  always_comb begin
    emptied_d = emptied_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    if (wr) begin
      emptied_d = 1'b0;
      pend_d    = 1'b0;
      if (cnt_q != WR_SAT) cnt_d = cnt_q + WRCNT_WIDTH'(1);
    end else if (!owned && (i_host_drain_done || pend_q)) begin
      emptied_d = 1'b1;
      cnt_d     = '0;
      pend_d    = 1'b0;
    end else if (owned && i_host_drain_done) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      g_q       <= '0;
      p_q       <= '0;
      grant_q   <= '0;
      emptied_q <= 1'b1;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      p_q       <= p_d;
      grant_q   <= grant_d;
      emptied_q <= emptied_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_core_grant   = grant_q;
  assign o_uram_emptied = emptied_q;
  assign o_wr_count     = cnt_q;

endmodule

// File: tb/tb_row_uram_arbiter.sv
// Directed bench for row_uram_arbiter: the stimulus pushes per-cycle expectations,
// and a negedge monitor pops them and compares them against the DUT outputs.
module tb_row_uram_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req, lock, grant, en, we;
  logic [47:0]  addr;
  logic [127:0] data;
  logic         u_en, u_we, drain, emptied;
  logic [11:0]  u_addr;
  logic [31:0]  u_data;
  logic [12:0]  cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          cg;
    logic [3:0]  g;
    bit          cm;
    logic        en;
    logic [11:0] addr;
    logic [31:0] data;
    logic        we;
    bit          cc;
    logic        emp;
    logic [12:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  row_uram_arbiter #(.NUM_CORES(4), .WRCNT_WIDTH(13)) dut (
    .clk               (clk),
    .reset             (reset),
    .i_core_req        (req),
    .i_core_locked     (lock),
    .o_core_grant      (grant),
    .i_URAM_en         (en),
    .i_URAM_addr       (addr),
    .i_URAM_wr_data    (data),
    .i_URAM_wr_en      (we),
    .o_URAM_en         (u_en),
    .o_URAM_addr       (u_addr),
    .o_URAM_wr_data    (u_data),
    .o_URAM_wr_en      (u_we),
    .i_host_drain_done (drain),
    .o_uram_emptied    (emptied),
    .o_wr_count        (cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0) cmp("grant_onehot0", 32'($countones(grant) <= 1), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e.cg) cmp("grant", 32'(grant), 32'(e.g));
      if (e.cm) begin
        cmp("uram_en", 32'(u_en), 32'(e.en));
        cmp("uram_addr", 32'(u_addr), 32'(e.addr));
        cmp("uram_data", u_data, e.data);
        cmp("uram_we", 32'(u_we), 32'(e.we));
      end
      if (e.cc) begin
        cmp("emptied", 32'(emptied), 32'(e.emp));
        cmp("wr_count", 32'(cnt), 32'(e.cnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xnone();
    exp_t e;
    e = '{cg: 1'b0, g: '0, cm: 1'b0, en: 1'b0, addr: '0, data: '0, we: 1'b0,
          cc: 1'b0, emp: 1'b0, cnt: '0};
    exp_q.push_back(e);
  endtask

  task automatic xall(input logic [3:0] g, input logic e_en, input logic [11:0] a,
                      input logic [31:0] d, input logic e_we, input logic emp,
                      input logic [12:0] c);
    exp_t e;
    e = '{cg: 1'b1, g: g, cm: 1'b1, en: e_en, addr: a, data: d, we: e_we,
          cc: 1'b1, emp: emp, cnt: c};
    exp_q.push_back(e);
  endtask

  task automatic xg(input logic [3:0] g);
    exp_t e;
    e = '{cg: 1'b1, g: g, cm: 1'b0, en: 1'b0, addr: '0, data: '0, we: 1'b0,
          cc: 1'b0, emp: 1'b0, cnt: '0};
    exp_q.push_back(e);
  endtask

  task automatic xgc(input logic [3:0] g, input logic emp, input logic [12:0] c);
    exp_t e;
    e = '{cg: 1'b1, g: g, cm: 1'b0, en: 1'b0, addr: '0, data: '0, we: 1'b0,
          cc: 1'b1, emp: emp, cnt: c};
    exp_q.push_back(e);
  endtask

  task automatic set_core(input int k, input logic e_en, input logic e_we,
                          input logic [11:0] a, input logic [31:0] d);
    en[k]          = e_en;
    we[k]          = e_we;
    addr[12*k +: 12] = a;
    data[32*k +: 32] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] oh;
    int w;
    reset = 1'b1; req = '0; lock = '0; en = '0; we = '0;
    addr = '0; data = '0; drain = 1'b0;
    repeat (2) @(posedge clk);

    // reset state, then 0101 request pattern
    tick(); reset = 1'b0; req = 4'b0101; xall(4'b0000, 0, 12'h0, 32'h0, 0, 1, 13'd0);
    tick(); xg(4'b0001);
    tick(); req = 4'b0100; xg(4'b0001);
    tick(); xg(4'b0000);
    tick(); req = 4'b0000; xg(4'b0100);
    tick(); xg(4'b0000);

    // core 1 holds ownership via lock while cores 0 and 3 request
    tick(); req = 4'b0010; xg(4'b0000);
    tick(); req = 4'b1001; lock = 4'b0010; xg(4'b0010);
    repeat (4) begin tick(); xg(4'b0010); end
    tick(); lock = 4'b0000; xg(4'b0010);
    tick(); xg(4'b0000);
    tick(); req = 4'b0000; xg(4'b1000);

    // all four requesting, each owner releases after two grant cycles
    for (int k = 0; k < 4; k++) begin
      oh = 4'b0001 << k;
      tick(); req = 4'b1111; xg(4'b0000);
      tick(); xg(oh);
      tick(); req = 4'b1111 & ~oh; xg(oh);
    end
    tick(); req = 4'b1111; xg(4'b0000);
    tick(); req = 4'b0000; xg(4'b0001);
    tick(); xg(4'b0000);

    // core 2 writes three words; non-granted core 0 drives junk
    tick(); req = 4'b0100; set_core(0, 1, 1, 12'h111, 32'h11111111);
    xall(4'b0000, 0, 12'h0, 32'h0, 0, 1, 13'd0);
    tick(); set_core(2, 1, 1, 12'h005, 32'hDEADBEEF);
    xall(4'b0100, 1, 12'h005, 32'hDEADBEEF, 1, 1, 13'd0);
    tick(); xall(4'b0100, 1, 12'h005, 32'hDEADBEEF, 1, 0, 13'd1);
    tick(); xall(4'b0100, 1, 12'h005, 32'hDEADBEEF, 1, 0, 13'd2);
    tick(); set_core(2, 0, 0, 12'h005, 32'hDEADBEEF); req = 4'b0000;
    xall(4'b0100, 0, 12'h005, 32'hDEADBEEF, 0, 0, 13'd3);
    tick(); drain = 1'b1; xall(4'b0000, 0, 12'h0, 32'h0, 0, 0, 13'd3);
    tick(); drain = 1'b0; set_core(0, 0, 0, 12'h0, 32'h0); xgc(4'b0000, 1, 13'd0);

    // drain during OWNED becomes pending until IDLE
    tick(); req = 4'b1000; xgc(4'b0000, 1, 13'd0);
    tick(); set_core(3, 1, 1, 12'h0AB, 32'h12345678);
    xall(4'b1000, 1, 12'h0AB, 32'h12345678, 1, 1, 13'd0);
    tick(); set_core(3, 0, 0, 12'h0AB, 32'h12345678); drain = 1'b1; xgc(4'b1000, 0, 13'd1);
    tick(); drain = 1'b0; req = 4'b0000; xgc(4'b1000, 0, 13'd1);
    tick(); xg(4'b0000);
    tick(); req = 4'b0001; xgc(4'b0000, 1, 13'd0);

    // write and drain in the same cycle: write wins, no pending drain left
    tick(); set_core(0, 1, 1, 12'h00F, 32'hCAFEF00D); drain = 1'b1;
    xall(4'b0001, 1, 12'h00F, 32'hCAFEF00D, 1, 1, 13'd0);
    tick(); set_core(0, 0, 0, 12'h0, 32'h0); drain = 1'b0; req = 4'b0000;
    xgc(4'b0001, 0, 13'd1);
    tick(); xgc(4'b0000, 0, 13'd1);
    tick(); req = 4'b0010; xgc(4'b0000, 0, 13'd1);

    // reset while core 1 owns the URAM
    tick(); reset = 1'b1; set_core(1, 1, 0, 12'h777, 32'h0BADF00D);
    xall(4'b0010, 1, 12'h777, 32'h0BADF00D, 0, 0, 13'd1);
    tick(); reset = 1'b0; req = 4'b1001; xall(4'b0000, 0, 12'h0, 32'h0, 0, 1, 13'd0);
    tick(); req = 4'b0000; set_core(1, 0, 0, 12'h0, 32'h0); xg(4'b0001);
    tick(); xg(4'b0000);

    // write counter saturation at 4096
    tick(); req = 4'b0010; xgc(4'b0000, 1, 13'd0);
    tick(); set_core(1, 1, 1, 12'h001, 32'h0000_0001); xgc(4'b0010, 1, 13'd0);
    for (int k = 1; k <= 4100; k++) begin
      tick();
      if (k == 1 || k == 4095 || k == 4096 || k == 4097 || k == 4100)
        xgc(4'b0010, 0, (k > 4096) ? 13'd4096 : 13'(k));
      else
        xnone();
    end
    tick(); set_core(1, 0, 0, 12'h0, 32'h0); req = 4'b0000; xgc(4'b0010, 0, 13'd4096);
    tick(); drain = 1'b1; xgc(4'b0000, 0, 13'd4096);
    tick(); drain = 1'b0; xgc(4'b0000, 1, 13'd0);

    w = 0;
    while (exp_q.size() != 0 && w < 10) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_queue: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
